// File: rtl/aligned_ram_pkg.sv
// rtl/aligned_ram_pkg.sv - shared types and helpers for the aligned RAM write scheduler
package aligned_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int ALIGN_BITS = 2;
    localparam int SAT_W      = 32;

    function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] lsbs);
        return lsbs == '0;
    endfunction

    // Callers zero-extend their counter to SAT_W and pass their own all-ones limit.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val >= max_val) ? val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/aligned_ram_wr_sched_rr_pick.sv
// rtl/aligned_ram_wr_sched_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int j;

    // Walk offsets from farthest to nearest so the requester closest to ptr_i wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aligned_ram_wr_sched.sv
// rtl/aligned_ram_wr_sched.sv - round-robin scheduler sharing one aligned RAM write port
module aligned_ram_wr_sched
    import aligned_ram_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]               req_ready,
    output logic [NREQ-1:0]               resp_valid,
    output logic [NREQ-1:0]               resp_err,
    output logic                          ram_wr_en,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic                          ram_error,
    output logic [CNT_W-1:0]              ok_cnt,
    output logic [CNT_W-1:0]              err_cnt
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    state_e              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic                err_q;
    logic                ram_wr_en_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic [NREQ-1:0]     resp_valid_q;
    logic [NREQ-1:0]     resp_err_q;
    logic [CNT_W-1:0]    ok_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;

    logic [NREQ-1:0]     pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [NREQ-1:0]     grant_oh;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [CNT_W-1:0]    ok_cnt_d;
    logic [CNT_W-1:0]    err_cnt_d;
    logic                pick_aligned;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign grant_oh     = NREQ'(1) << grant_q;
    assign rr_ptr_d     = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
    assign ok_cnt_d     = CNT_W'(sat_inc(SAT_W'(ok_cnt_q), CNT_MAX));
    assign err_cnt_d    = CNT_W'(sat_inc(SAT_W'(err_cnt_q), CNT_MAX));
    assign pick_aligned = is_aligned(req_addr[pick_idx][ALIGN_BITS-1:0]);

    // Acceptance is only offered while idle, so a response can never overlap a grant.
    assign req_ready  = (state_q == IDLE) ? pick_grant : '0;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign ram_wr_en  = ram_wr_en_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ok_cnt     = ok_cnt_q;
    assign err_cnt    = err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            err_q        <= 1'b0;
            ram_wr_en_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            ok_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        if (pick_aligned) begin
                            err_q       <= 1'b0;
                            ram_wr_en_q <= 1'b1;
                            ram_addr_q  <= req_addr[pick_idx];
                            ram_wdata_q <= req_wdata[pick_idx];
                            state_q     <= ISSUE;
                        end else begin
                            // Misaligned: answer directly, RAM port untouched.
                            err_q        <= 1'b1;
                            resp_valid_q <= pick_grant;
                            resp_err_q   <= pick_grant;
                            state_q      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    ram_wr_en_q <= 1'b0;
                    state_q     <= CHECK;
                end
                CHECK: begin
                    err_q        <= ram_error;
                    resp_valid_q <= grant_oh;
                    resp_err_q   <= ram_error ? grant_oh : '0;
                    state_q      <= RESP;
                end
                RESP: begin
                    rr_ptr_q <= rr_ptr_d;
                    if (err_q) begin
                        err_cnt_q <= err_cnt_d;
                    end else begin
                        ok_cnt_q <= ok_cnt_d;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aligned_ram_wr_sched.sv
// tb/tb_aligned_ram_wr_sched.sv - scoreboard bench for aligned_ram_wr_sched
module tb_aligned_ram_wr_sched;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_wdata;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         resp_valid;
    logic [NREQ-1:0]         resp_err;
    logic                    ram_wr_en;
    logic [AW-1:0]           ram_addr;
    logic [DW-1:0]           ram_wdata;
    logic                    ram_error;
    logic [CW-1:0]           ok_cnt;
    logic [CW-1:0]           err_cnt;

    aligned_ram_wr_sched #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_error(ram_error), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    typedef struct { int idx; logic err; int due; } resp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t mr;
    wr_t   mw;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    exp_ok  = 0;
    int    exp_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response or a RAM write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (|resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    mr = resp_q.pop_front();
                    check("resp_idx", 64'(resp_valid), 64'(1) << mr.idx);
                    check("resp_err", 64'(resp_err), mr.err ? (64'(1) << mr.idx) : 64'd0);
                    check("resp_cycle", 64'(cyc), 64'(mr.due));
                end
            end
            if (ram_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 64'(ram_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mw = wr_q.pop_front();
                    check("wr_addr", 64'(ram_addr), 64'(mw.addr));
                    check("wr_data", 64'(ram_wdata), 64'(mw.data));
                    check("wr_cycle", 64'(cyc), 64'(mw.due));
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic rerr);
        logic al;
        logic e;
        resp_t r;
        wr_t   w;
        al = (addr[1:0] == 2'b00);
        e  = !al || rerr;
        r.idx = idx; r.err = e; r.due = cyc + (al ? 3 : 1);
        resp_q.push_back(r);
        if (al) begin
            w.addr = addr; w.data = data; w.due = cyc + 1;
            wr_q.push_back(w);
        end
        if (e) begin
            if (exp_err < CMAX) exp_err++;
        end else begin
            if (exp_ok < CMAX) exp_ok++;
        end
    endtask

    task automatic wait_grant(output int g);
        int n;
        n = 0;
        g = -1;
        while (n < 40) begin
            #1;
            if (|req_ready) begin
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
                n = 99;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (g < 0) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic rerr);
        int g;
        @(negedge clk);
        ram_error      = rerr;
        req_addr[idx]  = addr;
        req_wdata[idx] = data;
        req_valid[idx] = 1'b1;
        wait_grant(g);
        if (g >= 0) begin
            check("grant_idx", 64'(g), 64'(idx));
            push_exp(idx, addr, data, rerr);
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (resp_q.size() != 0 || wr_q.size() != 0)
            check("drain_timeout", 64'(resp_q.size() + wr_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        resp_q.delete();
        wr_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int g;
        int prev_a;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        ram_error = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_wdata", 64'(ram_wdata), 64'd0);
        check("rst_ok", 64'(ok_cnt), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_resp", 64'({resp_valid, resp_err, req_ready}), 64'd0);

        do_req(0, 32'h100, 32'hDEADBEEF, 1'b0);
        drain();
        check("single_ok_cnt", 64'(ok_cnt), 64'(exp_ok));

        do_req(1, 32'h103, 32'h1234_5678, 1'b0);
        drain();
        check("mis_err_cnt", 64'(err_cnt), 64'(exp_err));
        check("mis_addr_hold", 64'(ram_addr), 64'h100);
        check("mis_data_hold", 64'(ram_wdata), 64'hDEADBEEF);

        do_req(2, 32'h200, 32'hCAFE_F00D, 1'b1);
        drain();
        check("fault_err_cnt", 64'(err_cnt), 64'(exp_err));
        check("fault_ok_cnt", 64'(ok_cnt), 64'(exp_ok));

        // All four requesters contend from reset.
        do_reset();
        ram_error = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k]  = 32'h1000 + 32'(k * 16);
            req_wdata[k] = 32'hA0 + 32'(k);
        end
        req_valid = '1;
        prev_a = 0;
        for (int s = 0; s < 5; s++) begin
            wait_grant(g);
            if (g >= 0) begin
                check("rot_order", 64'(g), 64'(order[s]));
                if (s > 0) check("rot_interval", 64'(cyc - prev_a), 64'd4);
                prev_a = cyc;
                push_exp(order[s], req_addr[order[s]], req_wdata[order[s]], 1'b0);
            end
            @(posedge clk);
            #1;
            if (s != 0) req_valid[order[s]] = 1'b0;
            @(negedge clk);
        end
        req_valid = '0;
        drain();
        check("rot_ok_cnt", 64'(ok_cnt), 64'(exp_ok));

        // Reset while the write is on the RAM port.
        do_req(3, 32'h300, 32'h3333_3333, 1'b0);
        check("pre_rst_wr_en", 64'(ram_wr_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("async_rst_cnts", 64'({ok_cnt, err_cnt}), 64'd0);
        check("async_rst_resp", 64'(resp_valid), 64'd0);
        resp_q.delete();
        wr_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_addr[0] = 32'h400; req_wdata[0] = 32'h4;
        req_addr[3] = 32'h430; req_wdata[3] = 32'h43;
        req_valid   = 4'b1001;
        wait_grant(g);
        check("post_rst_first", 64'(g), 64'd0);
        if (g >= 0) push_exp(0, 32'h400, 32'h4, 1'b0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        wait_grant(g);
        check("post_rst_second", 64'(g), 64'd3);
        if (g >= 0) push_exp(3, 32'h430, 32'h43, 1'b0);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
        check("post_rst_ok", 64'(ok_cnt), 64'(exp_ok));

        // Saturation of the rejected-request counter.
        for (int i = 0; i < CMAX; i++) do_req(1, 32'h501, 32'(i), 1'b0);
        drain();
        check("sat_reach", 64'(err_cnt), 64'(CMAX));
        do_req(1, 32'h502, 32'hFF, 1'b0);
        drain();
        check("sat_hold", 64'(err_cnt), 64'(CMAX));
        check("sat_ok_unchanged", 64'(ok_cnt), 64'(exp_ok));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
